ab_arbiter: RTL
===============

# ab_arbiter

Two-requester arbiter that shares one downstream resource between requester A and requester B. Grants the resource to one requester at a time and breaks ties round-robin. Caps each tenure at a programmable hold limit and inserts a programmable idle gap between tenures. Sits in front of the shared FSM/datapath and drives its enable/select from `gnt_a`/`gnt_b`.

## Interface
- `MAX_HOLD`, default 8: maximum grant length in cycles, legal range 1..255.
- `GAP`, default 1: idle cycles between a release and the next grant, legal range 1..15.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `req_a` input 1: requester A wants the resource; level-sensitive.
- `req_b` input 1: requester B wants the resource; level-sensitive.
- `done_a` input 1: A finished; honoured only while `gnt_a`=1.
- `done_b` input 1: B finished; honoured only while `gnt_b`=1.
- `gnt_a` output 1: A owns the resource.
- `gnt_b` output 1: B owns the resource.
- `busy` output 1: `gnt_a | gnt_b`.
- `owner` output 1: last requester served (0=A, 1=B).
- `timeout` output 1: one-cycle pulse when a tenure is forcibly ended.
- `hold_cnt` output 8: cycles elapsed in the current tenure.

## Operation
- **States:** IDLE, GNT_A, GNT_B, GAP. All outputs are registered (Moore).
- **Reset values:** state=IDLE, `gnt_a`=0, `gnt_b`=0, `busy`=0, `timeout`=0, `hold_cnt`=0, `owner`=1. With `owner`=1, A wins the first tie.
- **IDLE:**
  - `req_a` only -> GNT_A.
  - `req_b` only -> GNT_B.
  - Both requesting -> grant the requester ≠ `owner`.
  - Neither requesting -> stay in IDLE.
- **Entering GNT_X:** `hold_cnt`<=1 and `owner`<=X.
- **In GNT_X:** `hold_cnt` increments by 1 per cycle and saturates at `MAX_HOLD`. Release on the first of:
  - `done_x`=1
  - `req_x`=0
  - `hold_cnt`==`MAX_HOLD`
- **On release:** go to GAP, with `hold_cnt`<=0 and the gap counter <=`GAP`-1.
- **Timeout:** if the release is caused only by the hold limit (`done_x`=0 and `req_x`=1), `timeout` pulses high in the first GAP cycle. If `done_x` is high in the limit cycle, the release is normal and there is no pulse.
- **GAP:** both grants low. The counter decrements; when it reaches 0, go to IDLE.
- **Ignored inputs:** `done_a`/`done_b` are ignored outside their own grant.
- **Mutual exclusion:** `gnt_a` and `gnt_b` are never both 1.

## Timing
- **Grant latency:** request sampled high in IDLE at edge n -> grant high after edge n (1 cycle).
- **Release latency:** release condition at edge n -> grant low after edge n.
- **Tenure length:** the grant lasts at most `MAX_HOLD` cycles.
- **Minimum gap:** at least `GAP`+1 grant-low cycles between consecutive tenures (`GAP` cycles in GAP plus 1 cycle in IDLE).
- **Back-to-back, same requester:** a requester that keeps `req` high after `done` must re-arbitrate in IDLE. If the other requester is also requesting, the other one wins.
- **Simultaneous release and new request:** requests arriving during GNT_X or GAP are not lost because they are levels. They are evaluated in IDLE.
- **Reset mid-tenure:** grants drop asynchronously on `reset` falling. There is no `timeout` pulse, and `owner` returns to 1.
- **Saturation:** `hold_cnt` never exceeds `MAX_HOLD` and never wraps.

## Structure
- **Package `ab_arb_pkg`:**
  - state enum: IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10, GAP=2'b11
  - constants `OWNER_A`=1'b0, `OWNER_B`=1'b1
- **Sub-module `ab_hold_timer`:** loadable up/down 8-bit counter shared by the hold count and the gap count. Ports: load, load value, up, down, saturate limit, count out.
- **Top level:** the FSM, the tie-break logic and the output registers.

## Test plan
Parameters `MAX_HOLD`=4, `GAP`=2 unless stated.
- **Tie after reset:** `reset` released, `req_a`=`req_b`=1 from cycle 2 -> `gnt_a`=1 at cycle 3, `owner`=0, `gnt_b`=0.
- **Normal done:** A granted, `done_a`=1 at the 2nd grant cycle -> `gnt_a`=0 the next cycle. Then 3 grant-low cycles, then `gnt_b`=1 (B still requesting), `timeout` never high.
- **Timeout:** A holds `req_a`=1 with `done_a`=0 -> `gnt_a` high exactly 4 cycles, `hold_cnt` 1,2,3,4, then a `timeout` pulse for 1 cycle.
- **Round-robin fairness:** both requests held high for 40 cycles -> grants strictly alternate A, B, A, B. No `done_x` is driven, so every tenure ends at the hold limit and each 4-cycle grant is followed by a `timeout` pulse.
- **Stray done and drop:** `done_b`=1 while A is granted -> no effect. `req_a` dropped mid-tenure -> `gnt_a`=0 the next cycle with no `timeout`.
- **Reset mid-grant:** `reset`=0 while `gnt_b`=1 -> `gnt_b`=0 immediately. After release, a tie grants A first.

Source files
------------

// File: rtl/ab_arb_pkg.sv
// Shared types and constants for the two-requester arbiter.
// Also holds the round-robin tie-break rule.
package ab_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10,
    GAP   = 2'b11
  } arb_state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // A wins when it is the only requester, or on a tie when B was served last.
  function automatic logic a_wins(input logic req_a, input logic req_b, input logic owner);
    return req_a && (!req_b || owner == OWNER_B);
  endfunction

endpackage

// File: rtl/ab_hold_timer.sv
// Loadable 8-bit up/down counter used for both the tenure length and the idle gap.
// Counting up saturates at limit; counting down stops at zero; load has priority.
module ab_hold_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       up,
  input  logic       down,
  input  logic [7:0] limit,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (up && count < limit) begin
      count <= count + 8'd1;
    end else if (down && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

endmodule

// File: rtl/ab_arbiter.sv
// Round-robin arbiter for two requesters with a capped tenure and an idle gap between grants.
// All outputs come from registers; grants rise one cycle after a request is seen in IDLE.
module ab_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned GAP      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       done_a,
  input  logic       done_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic       owner,
  output logic       timeout,
  output logic [7:0] hold_cnt
);
  import ab_arb_pkg::*;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

  arb_state_t state, state_nxt;
  logic       gnt_a_nxt, gnt_b_nxt, owner_nxt, timeout_nxt;
  logic       load, up, down;
  logic [7:0] load_val, cnt;
  logic       cur_req, cur_done;

  assign cur_req  = (state == GNT_A) ? req_a  : req_b;
  assign cur_done = (state == GNT_A) ? done_a : done_b;

  ab_hold_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .up       (up),
    .down     (down),
    .limit    (HOLD_LIM),
    .count    (cnt)
  );

  always_comb begin
    state_nxt   = state;
    gnt_a_nxt   = 1'b0;
    gnt_b_nxt   = 1'b0;
    owner_nxt   = owner;
    timeout_nxt = 1'b0;
    load        = 1'b0;
    load_val    = 8'd0;
    up          = 1'b0;
    down        = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          load     = 1'b1;
          load_val = 8'd1;
          if (a_wins(req_a, req_b, owner)) begin
            state_nxt = GNT_A;
            gnt_a_nxt = 1'b1;
            owner_nxt = OWNER_A;
          end else begin
            state_nxt = GNT_B;
            gnt_b_nxt = 1'b1;
            owner_nxt = OWNER_B;
          end
        end
      end
      GNT_A, GNT_B: begin
        if (cur_done || !cur_req || cnt == HOLD_LIM) begin
          // Only a limit-forced release (still requesting, not done) is a timeout.
          state_nxt   = ab_arb_pkg::GAP;
          load        = 1'b1;
          load_val    = GAP_LOAD;
          timeout_nxt = cur_req && !cur_done;
        end else begin
          up        = 1'b1;
          gnt_a_nxt = (state == GNT_A);
          gnt_b_nxt = (state == GNT_B);
        end
      end
      default: begin
        if (cnt == 8'd0) state_nxt = IDLE;
        else             down      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      owner   <= OWNER_B;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt_a   <= gnt_a_nxt;
      gnt_b   <= gnt_b_nxt;
      owner   <= owner_nxt;
      timeout <= timeout_nxt;
    end
  end

  // The shared counter holds the gap count outside a tenure, so mask it there.
  assign busy     = gnt_a | gnt_b;
  assign hold_cnt = busy ? cnt : 8'd0;

endmodule
